// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : two-requester round-robin sequencer for a single-port memory
//               with registered read data; returns done/err per requester.
// Rev 1.0
// ============================================================================
module mem_arbiter #(
  parameter int SIZE = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_memW,
  input  logic [31:0] mem_readData
);

  localparam logic [31:0] c_SIZE = 32'(SIZE);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t r_state;
  logic   r_id;
  logic   r_we;
  logic   r_err;
  logic   r_last_grant;

  logic        w_both;
  logic        w_sel;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_in_range;

  // A tie goes to whichever requester was not granted on the previous tie.
  assign w_both     = req0 & req1;
  assign w_sel      = w_both ? ~r_last_grant : req1;
  assign w_we       = w_sel ? we1    : we0;
  assign w_addr     = w_sel ? addr1  : addr0;
  assign w_wdata    = w_sel ? wdata1 : wdata0;
  assign w_in_range = (w_addr < c_SIZE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_id         <= 1'b0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_last_grant <= 1'b1;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      rdata0       <= 32'h0;
      rdata1       <= 32'h0;
      mem_address  <= 32'h0;
      mem_data     <= 32'h0;
      mem_memW     <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 | req1) begin
            r_id  <= w_sel;
            r_we  <= w_we;
            r_err <= ~w_in_range;
            if (w_both) r_last_grant <= w_sel;
            if (w_sel) gnt1 <= 1'b1;
            else       gnt0 <= 1'b1;
            // The memory port registers double as the latched payload;
            // an out-of-range access never touches them.
            if (w_in_range) begin
              mem_address <= w_addr;
              mem_data    <= w_wdata;
              mem_memW    <= w_we;
            end
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          mem_memW <= 1'b0;
          r_state  <= (r_we | r_err) ? S_RESP : S_CAPTURE;
        end
        S_CAPTURE: begin
          if (r_id) rdata1 <= mem_readData;
          else      rdata0 <= mem_readData;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (r_id) begin
            done1 <= 1'b1;
            err1  <= r_err;
            if (r_err && !r_we) rdata1 <= 32'h0;
          end else begin
            done0 <= 1'b1;
            err0  <= r_err;
            if (r_err && !r_we) rdata0 <= 32'h0;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter : directed stimulus, transaction-schedule reference model and
// per-cycle comparison for mem_arbiter.
module tb_mem_arbiter;

  localparam int SIZE = 32;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, done0, done1, err0, err1, mem_memW;
  logic [31:0] rdata0, rdata1, mem_address, mem_data, mem_readData;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_data(mem_data), .mem_memW(mem_memW),
    .mem_readData(mem_readData)
  );

  // Single-port memory with registered read data.
  logic [31:0] mem [SIZE];
  always @(posedge clk) begin
    if (mem_memW && mem_address < SIZE) mem[mem_address[4:0]] <= mem_data;
    mem_readData <= (mem_address < SIZE) ? mem[mem_address[4:0]] : 32'h0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: every accepted request books its whole response
  // schedule (cycle offsets from the accepting edge) into these tables.
  int          cyc = 0;
  int          free_at = 0;
  bit          lg = 1'b1;
  logic [31:0] ref_mem [SIZE];
  bit          e_gnt [2][MAXC];
  bit          e_done[2][MAXC];
  bit          e_err [2][MAXC];
  bit          e_rdu [2][MAXC];
  logic [31:0] e_rdv [2][MAXC];
  bit          e_acc [MAXC];
  bit          e_memw[MAXC];
  logic [31:0] e_addr[MAXC];
  logic [31:0] e_data[MAXC];

  task automatic clear_slot(input int i);
    for (int d = 0; d < 2; d++) begin
      e_gnt[d][i] = 0; e_done[d][i] = 0; e_err[d][i] = 0;
      e_rdu[d][i] = 0; e_rdv[d][i] = '0;
    end
    e_acc[i] = 0; e_memw[i] = 0;
  endtask

  initial forever begin : model
    bit          id, w, inr;
    logic [31:0] a, d;
    int          lat, last;
    @(posedge clk);
    cyc = cyc + 1;
    if (!reset) begin
      lg = 1'b1;
      free_at = cyc + 1;
      for (int j = 0; j < 4; j++) clear_slot(cyc + j);
    end else if (cyc >= free_at && (req0 || req1)) begin
      if (req0 && req1) begin
        id = ~lg;
        lg = id;
      end else begin
        id = req1;
      end
      w   = id ? we1 : we0;
      a   = id ? addr1 : addr0;
      d   = id ? wdata1 : wdata0;
      inr = (a < SIZE);
      lat = !inr ? 3 : (w ? 3 : 4);
      last = cyc + lat - 1;
      e_gnt[id][cyc]   = 1;
      e_done[id][last] = 1;
      e_err[id][last]  = !inr;
      if (inr) begin
        e_acc[cyc] = 1; e_addr[cyc] = a; e_data[cyc] = d; e_memw[cyc] = w;
        if (w) ref_mem[a[4:0]] = d;
        else begin e_rdu[id][last] = 1; e_rdv[id][last] = ref_mem[a[4:0]]; end
      end else if (!w) begin
        e_rdu[id][last] = 1; e_rdv[id][last] = 32'h0;
      end
      free_at = cyc + lat;
    end
  end

  initial forever begin : compare
    logic [31:0] m_rd0, m_rd1;
    @(negedge clk);
    if (cyc > 0) begin
      if (!reset) begin
        m_rd0 = '0; m_rd1 = '0;
        chk("reset_ctl", {gnt0, gnt1, done0, done1, err0, err1, mem_memW}, '0);
        chk("reset_rdata", {rdata0, rdata1}, '0);
        chk("reset_mem", {mem_address, mem_data}, '0);
      end else begin
        if (e_rdu[0][cyc]) m_rd0 = e_rdv[0][cyc];
        if (e_rdu[1][cyc]) m_rd1 = e_rdv[1][cyc];
        chk("gnt", {gnt0, gnt1}, {e_gnt[0][cyc], e_gnt[1][cyc]});
        chk("done_err", {done0, err0, done1, err1},
            {e_done[0][cyc], e_err[0][cyc], e_done[1][cyc], e_err[1][cyc]});
        chk("memW", mem_memW, e_memw[cyc]);
        if (e_acc[cyc]) chk("mem_addr_data", {mem_address, mem_data}, {e_addr[cyc], e_data[cyc]});
        if (e_done[0][cyc]) chk("rdata0", rdata0, m_rd0);
        if (e_done[1][cyc]) chk("rdata1", rdata1, m_rd1);
      end
    end
  end

  task automatic drive(input int id, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (id == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else         begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // sel: 0 gnt0, 1 gnt1, 2 done0, 3 done1. n = negedges waited, 0 if never seen.
  task automatic wait_for(input int sel, input int budget, output int n);
    bit hit = 0;
    n = 0;
    for (int k = 1; k <= budget && !hit; k++) begin
      @(negedge clk);
      case (sel)
        0: hit = gnt0;
        1: hit = gnt1;
        2: hit = done0;
        default: hit = done1;
      endcase
      if (hit) n = k;
    end
  endtask

  task automatic xact(input int id, input bit w, input logic [31:0] a, input logic [31:0] d,
                      output int tg, output int td);
    int n;
    @(negedge clk); #2;
    drive(id, 1, w, a, d);
    wait_for(id, 10, tg);
    #2 drive(id, 0, 0, '0, '0);
    wait_for(2 + id, 10, n);
    td = (n == 0 || tg == 0) ? 0 : tg + n;
  endtask

  initial begin
    #30000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int tg, td, n, c0, c1, first, tdone, tg1;
    bit both, early;
    int order[$];
    for (int i = 0; i < SIZE; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    repeat (3) @(negedge clk);
    chk("reset_literal", {gnt0, gnt1, done0, done1, rdata0}, '0);
    #2 reset = 1'b1;

    xact(0, 1, 32'd5, 32'hDEADBEEF, tg, td);
    chk("w5_gnt_lat", tg, 1); chk("w5_done_lat", td, 3); chk("w5_err", err0, 0);
    xact(0, 0, 32'd5, '0, tg, td);
    chk("r5_gnt_lat", tg, 1); chk("r5_done_lat", td, 4); chk("r5_data", rdata0, 32'hDEADBEEF);
    xact(1, 1, 32'd31, 32'h12345678, tg, td);
    chk("w31_done_lat", td, 3); chk("w31_err", err1, 0);
    xact(1, 1, 32'd32, 32'hCAFEF00D, tg, td);
    chk("w32_done_lat", td, 3); chk("w32_err", err1, 1);
    xact(1, 1, 32'h8000_0005, 32'h0BAD0BAD, tg, td);
    chk("whigh_err", err1, 1);
    xact(1, 0, 32'd31, '0, tg, td);
    chk("r31_done_lat", td, 4); chk("r31_data", rdata1, 32'h12345678); chk("r31_err", err1, 0);
    xact(0, 0, 32'hFFFF_FFFF, '0, tg, td);
    chk("rmax_done_lat", td, 3); chk("rmax_err", err0, 1); chk("rmax_data", rdata0, 0);
    xact(0, 0, 32'd5, '0, tg, td);
    chk("r5_unaliased", rdata0, 32'hDEADBEEF);

    // Both requesters hold reads for three transactions each.
    c0 = 0; c1 = 0; both = 0;
    @(negedge clk); #2;
    drive(0, 1, 0, 32'd5, '0); drive(1, 1, 0, 32'd31, '0);
    for (int k = 0; k < 60 && (c0 < 3 || c1 < 3); k++) begin
      @(negedge clk);
      if (gnt0 && gnt1) both = 1;
      if (gnt0) begin order.push_back(0); c0++; end
      if (gnt1) begin order.push_back(1); c1++; end
      #2;
      if (c0 >= 3) req0 = 0;
      if (c1 >= 3) req1 = 0;
    end
    chk("rr_no_double_gnt", both, 0);
    chk("rr_count", order.size(), 6);
    for (int i = 0; i < 6; i++) chk("rr_order", (i < order.size()) ? order[i] : 9, i % 2);
    wait_for(3, 10, n);
    chk("rr_last_done1", n, 3);

    // Reset lands in CAPTURE of a read.
    @(negedge clk); #2;
    drive(0, 1, 0, 32'd5, '0);
    wait_for(0, 10, n);
    chk("cap_gnt_lat", n, 1);
    #2 drive(0, 0, 0, '0, '0);
    @(negedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("cap_reset_outs", {gnt0, done0, err0, mem_memW, rdata0, rdata1}, '0);
    #2 reset = 1'b1;
    wait_for(2, 6, n);
    chk("cap_no_done", n, 0);
    first = 9; c0 = 0; c1 = 0;
    @(negedge clk); #2;
    drive(0, 1, 1, 32'd7, 32'hAAAA0007); drive(1, 1, 1, 32'd8, 32'hBBBB0008);
    for (int k = 0; k < 20 && (c0 < 1 || c1 < 1); k++) begin
      @(negedge clk);
      if (gnt0) begin if (first == 9) first = 0; c0++; end
      if (gnt1) begin if (first == 9) first = 1; c1++; end
      #2;
      if (c0 >= 1) req0 = 0;
      if (c1 >= 1) req1 = 0;
    end
    chk("post_reset_first", first, 0);
    wait_for(3, 10, n);
    chk("post_reset_done1", n, 2);

    // req1 arrives while req0's write is in flight.
    @(negedge clk); #2;
    drive(0, 1, 1, 32'd10, 32'h5A5AA5A5);
    wait_for(0, 10, n);
    chk("busy_gnt0_lat", n, 1);
    #2 drive(0, 0, 0, '0, '0); drive(1, 1, 0, 32'd10, '0);
    tdone = 0; tg1 = 0; early = 0;
    for (int k = 1; k <= 12 && tg1 == 0; k++) begin
      @(negedge clk);
      if (done0 && tdone == 0) tdone = k;
      if (gnt1) begin tg1 = k; if (tdone == 0) early = 1; end
    end
    #2 drive(1, 0, 0, '0, '0);
    chk("busy_gnt1_held", early, 0);
    chk("busy_done0_off", tdone, 2);
    chk("busy_gnt1_after_done0", tg1 - tdone, 1);
    wait_for(3, 10, n);
    chk("busy_rd_lat", n, 3);
    chk("busy_rd_data", rdata1, 32'h5A5AA5A5);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
